// File: rtl/jk_toggle_monitor_pkg.sv
// Shared types and defaults for the jk_toggle_monitor measurement block:
// FSM state encodings and default counter widths.
package jk_toggle_monitor_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_WIN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/jk_toggle_monitor_if.sv
// Control/result bundle between a measurement requester (master) and the
// jk_toggle_monitor (slave).
interface jk_toggle_monitor_if
    import jk_toggle_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) ();

    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [WIN_W-1:0] high_cyc;

    modport master (
        output start, win_len,
        input  busy, done, rise_cnt, fall_cnt, high_cyc
    );

    modport slave (
        input  start, win_len,
        output busy, done, rise_cnt, fall_cnt, high_cyc
    );

endinterface

// File: rtl/jk_toggle_monitor_edge_det_sync.sv
// edge_det_sync block: optional 2-flop synchronizer (JK_TOGGLE_MONITOR_SYNC_EN),
// q_prev register and rise/fall pulses; load refreshes q_prev without a pulse.
module jk_toggle_monitor_edge_det_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic load,
    output logic q_s,
    output logic rise,
    output logic fall
);

    logic q_prev_q, q_prev_d;

`ifdef JK_TOGGLE_MONITOR_SYNC_EN
    logic meta_q, meta_d, sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_s = sync_q;
`else
    assign q_s = d;
`endif

    always_comb q_prev_d = q_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_prev_q <= 1'b0;
        else     q_prev_q <= q_prev_d;
    end

    assign rise = ~load &  q_s & ~q_prev_q;
    assign fall = ~load & ~q_s &  q_prev_q;

endmodule

// File: rtl/jk_toggle_monitor.sv
// Windowed rise/fall/high-cycle monitor for the jkff output; results presented
// with a done pulse. Define JK_TOGGLE_MONITOR_SYNC_EN to synchronize q_in.
//
// state | meaning
// IDLE  | waiting for start, results held
// ARM   | sample reference q, load remaining-cycle counter
// MEAS  | count edges and high cycles until the window ends
// DONE  | one-cycle done pulse, results valid
module jk_toggle_monitor
    import jk_toggle_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_in,
    jk_toggle_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d, rem_q, rem_d, high_q, high_d;
    logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             q_s, rise, fall, load;

    assign load = (state_q == ARM);

    jk_toggle_monitor_edge_det_sync u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (q_in),
        .load (load),
        .q_s  (q_s),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            rem_q   <= '0;
            high_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            high_q  <= high_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rem_d   = rem_q;
        high_d  = high_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    win_d   = bus.win_len;
                    high_d  = '0;
                    rise_d  = '0;
                    fall_d  = '0;
                    state_d = (bus.win_len == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                rem_d   = win_q;
                state_d = MEAS;
            end
            MEAS: begin
                // edge counters stick at all-ones; high_cyc is bounded by win_len
                if (rise && (rise_q != '1)) rise_d = rise_q + CNT_ONE;
                if (fall && (fall_q != '1)) fall_d = fall_q + CNT_ONE;
                if (q_s)                    high_d = high_q + WIN_ONE;
                rem_d = rem_q - WIN_ONE;
                if (rem_q == WIN_ONE) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rise_cnt = rise_q;
    assign bus.fall_cnt = fall_q;
    assign bus.high_cyc = high_q;

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Directed bench for jk_toggle_monitor: a jkff model drives q_in, expected
// results are queued at start and compared on done; a CNT_W=2 copy runs in lockstep.
module tb_jk_toggle_monitor;
    import jk_toggle_monitor_pkg::*;

    typedef struct {
        int rise;
        int fall;
        int high;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, j, k, jk_q;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

`ifdef JK_TOGGLE_MONITOR_SYNC_EN
    localparam int S0 = -1;
`else
    localparam int S0 = 1;
`endif

    always #5 clk = ~clk;

    jk_toggle_monitor_if #(.CNT_W(8), .WIN_W(8)) bus ();
    jk_toggle_monitor_if #(.CNT_W(2), .WIN_W(8)) bus2 ();

    assign bus2.start   = bus.start;
    assign bus2.win_len = bus.win_len;

    jk_toggle_monitor #(.CNT_W(8), .WIN_W(8)) dut (
        .clk(clk), .rst(rst), .q_in(jk_q), .bus(bus)
    );
    jk_toggle_monitor #(.CNT_W(2), .WIN_W(8)) dut2 (
        .clk(clk), .rst(rst), .q_in(jk_q), .bus(bus2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) jk_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   jk_q <= 1'b0;
                2'b10:   jk_q <= 1'b1;
                2'b11:   jk_q <= ~jk_q;
                default: jk_q <= jk_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sat2(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // pat: 0 hold, 1 toggle, 2 set x3 then reset x3
    function automatic logic [1:0] jk_at(input int pat, input int idx);
        if (idx < 0) return 2'b00;
        case (pat)
            1:       return 2'b11;
            2:       return (idx < 3) ? 2'b10 : (idx < 6) ? 2'b01 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic run(input int win, input logic init, input int pat, input int xs,
                       input int er, input int ef, input int eh);
        exp_t e, g;
        bit   got;
        j = init; k = ~init;
        repeat (3) @(negedge clk);
        j = 1'b0; k = 1'b0;
        got = 1'b0;
        for (int t = -2; t <= 40; t++) begin
            @(negedge clk);
            if (t >= 1 && bus.done === 1'b1 && !got) begin
                got = 1'b1;
                g = sb.pop_front();
                chk("latency", t, g.lat);
                chk("rise_cnt", bus.rise_cnt, g.rise);
                chk("fall_cnt", bus.fall_cnt, g.fall);
                chk("high_cyc", bus.high_cyc, g.high);
                chk("busy_in_done", bus.busy, 1);
                chk("rise_cnt_w2", bus2.rise_cnt, sat2(g.rise));
                chk("fall_cnt_w2", bus2.fall_cnt, sat2(g.fall));
                chk("high_cyc_w2", bus2.high_cyc, g.high);
            end
            if (t == 1) chk("busy_after_start", bus.busy, 1);
            bus.start = (t == 0) || (t == xs);
            if (t == 0) begin
                bus.win_len = win[7:0];
                e.rise = er; e.fall = ef; e.high = eh;
                e.lat  = (win == 0) ? 1 : win + 2;
                sb.push_back(e);
            end else if (t == xs) begin
                bus.win_len = 8'd3;
            end
            {j, k} = jk_at(pat, t - S0);
            if (got) break;
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL done_timeout observed=no_done expected=done");
        end
        if (!got && sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
        chk("rise_hold", bus.rise_cnt, er);
        chk("high_hold", bus.high_cyc, eh);
        bus.start = 1'b0;
        j = 1'b0; k = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("start_not_queued", bus.busy, 0);
        end
    endtask

`ifdef JK_TOGGLE_MONITOR_SYNC_EN
    logic [2:0] qh = 3'b000;
    int         hv = 0;
    always @(negedge clk) begin
        qh = {qh[1:0], jk_q};
        if (rst) hv = 0;
        else if (hv < 3) hv++;
        if (hv >= 3) chk("q_s_lag2", dut.u_edge.q_s, qh[2]);
    end
`endif

    initial begin
        bit seen;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.win_len = 8'd0;
        j = 1'b0; k = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rise", bus.rise_cnt, 0);
        chk("rst_fall", bus.fall_cnt, 0);
        chk("rst_high", bus.high_cyc, 0);
        chk("rst_state", dut.state_q, IDLE);
        rst = 1'b0;

        run(6, 1'b1, 0, -100, 0, 0, 6);    // hold high
        run(8, 1'b0, 1, -100, 4, 4, 4);    // toggle
        run(6, 1'b0, 2, -100, 1, 1, 3);    // set then reset
        run(0, 1'b1, 0, -100, 0, 0, 0);    // zero-length window
        run(10, 1'b0, 1, 4, 5, 5, 5);      // start during MEAS ignored
        run(2, 1'b1, 0, 4, 0, 0, 2);       // start in DONE cycle ignored
        run(12, 1'b0, 1, -100, 6, 6, 6);   // saturates the CNT_W=2 copy

        // abort in the third MEAS cycle
        j = 1'b1; k = 1'b0;
        repeat (3) @(negedge clk);
        j = 1'b0; k = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.win_len = 8'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", bus.busy, 1);
        chk("abort_pre_high", bus.high_cyc, 2);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rise", bus.rise_cnt, 0);
        chk("abort_fall", bus.fall_cnt, 0);
        chk("abort_high", bus.high_cyc, 0);
        chk("abort_state", dut.state_q, IDLE);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        run(3, 1'b1, 0, -100, 0, 0, 3);    // normal run after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
